add_seq_multiword: RTL and testbench

//  Multi-cycle, multi-operand adder. Sums NARG operands of LEN*WORDS bits,
//  fed as WORDS beats of LEN bits, least significant word first.

---
 rtl/add_seq_multiword.sv | 139 +++++++++++++
 tb/tb_add_seq_multiword.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_multiword.sv
// add_seq_multiword
//
// Multi-cycle, multi-operand adder. NARG operands of LEN*WORDS bits arrive
// as WORDS beats of LEN bits, least significant word first. The carry from
// each beat is held in a register and added into the next one. Every accepted
// input beat produces exactly one output beat one cycle later.
//
// Parameters:
//   LEN    word width per beat
//   NARG   operand count (2..4)
//   WORDS  beats per transaction (>=1)
//   CW     carry width, derived: 1 for NARG==2, 2 otherwise
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid & in_ready
//   A            packed operands, operand k = A[k*LEN +: LEN]
//   IC           carry-in, used only on the first beat of a transaction
//   out_valid    output beat valid
//   out_ready    downstream accepts when out_valid & out_ready
//   Y            sum word for this beat
//   out_last     high on the final beat of a transaction
//   OC           unsigned carry-out of the whole sum (last beat only, else 0)
//   OVF          signed overflow of the whole sum (last beat only, else 0)
//
// Optional build macro ADD_OVF_STICKY_EN adds:
//   ovf_clr      clears the sticky overflow flag
//   ovf_sticky   set by any last beat reporting OVF; set beats clear

module add_seq_multiword #(
    parameter  int LEN   = 16,
    parameter  int NARG  = 2,
    parameter  int WORDS = 4,
    localparam int CW    = (NARG == 2) ? 1 : 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NARG*LEN-1:0] A,
    input  logic [CW-1:0]       IC,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN-1:0]      Y,
    output logic                out_last,
    output logic [CW-1:0]       OC,
    output logic                OVF
`ifdef ADD_OVF_STICKY_EN
    ,
    input  logic                ovf_clr,
    output logic                ovf_sticky
`endif
);

    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
    localparam int SW = LEN + CW;

    logic [BW-1:0] beat_cnt;
    logic [CW-1:0] carry_q;
    logic          accept;
    logic          first_beat;
    logic          last_beat;
    logic [CW-1:0] cin;
    logic [SW-1:0] sum_full;
    logic [CW:0]   neg_cnt;
    logic [CW:0]   upper_signed;
    logic          ovf_next;

    // The single output register frees up whenever it is empty or being drained.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign cin        = first_beat ? IC : carry_q;

    // Unsigned sum of this beat's words plus the incoming carry. The signed
    // view of the top word is derived from the same sum: sign-extending each
    // negative operand subtracts one from the bits above LEN, so the upper
    // signed bits are the unsigned carry minus the count of negative words.
    // Overflow means those upper bits are not a pure sign extension of the
    // result word.
    always_comb begin
        sum_full = SW'(cin);
        neg_cnt  = '0;
        for (int k = 0; k < NARG; k++) begin
            sum_full = sum_full + SW'(A[k*LEN +: LEN]);
            neg_cnt  = neg_cnt + (CW+1)'(A[k*LEN + LEN - 1]);
        end
        upper_signed = {1'b0, sum_full[SW-1:LEN]} - neg_cnt;
        ovf_next     = (upper_signed != {(CW+1){sum_full[LEN-1]}});
    end

    // Beat counter, carry register and output register. A stalled output
    // holds everything; a drained output with nothing new just drops valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            carry_q   <= '0;
            out_valid <= 1'b0;
            Y         <= '0;
            out_last  <= 1'b0;
            OC        <= '0;
            OVF       <= 1'b0;
        end else if (accept) begin
            Y         <= sum_full[LEN-1:0];
            carry_q   <= sum_full[SW-1:LEN];
            out_valid <= 1'b1;
            out_last  <= last_beat;
            if (last_beat) begin
                beat_cnt <= '0;
                OC       <= sum_full[SW-1:LEN];
                OVF      <= ovf_next;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                OC       <= '0;
                OVF      <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADD_OVF_STICKY_EN
    // Sticky overflow flag. A setting event in the same cycle as a clear
    // request wins, so an overflow is never silently lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (accept && last_beat && ovf_next) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_add_seq_multiword.sv
// tb_add_seq_multiword
//
// Bench for add_seq_multiword with LEN=16, WORDS=2. Two instances run in
// lockstep on the same handshake signals: one with NARG=4 and one with
// NARG=2 (fed operands 0 and 1 and bit 0 of the carry-in). Expected beats
// come from whole-transaction arithmetic on 32-bit operands and are queued
// on acceptance; a monitor pops and compares on every output handshake.

module tb_add_seq_multiword;

    typedef logic [3:0][31:0] ops_t;

    typedef struct {
        logic [15:0] y4;
        logic [15:0] y2;
        logic        last;
        logic [1:0]  oc4;
        logic        oc2;
        logic        ovf4;
        logic        ovf2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a4;
    logic [31:0] a2;
    logic [1:0]  ic4;
    logic [0:0]  ic2;

    logic        in_ready4, out_valid4, out_last4, ovf4;
    logic [15:0] y4;
    logic [1:0]  oc4;
    logic        in_ready2, out_valid2, out_last2, ovf2;
    logic [15:0] y2;
    logic [0:0]  oc2;
`ifdef ADD_OVF_STICKY_EN
    logic        ovf_clr;
    logic        sticky4, sticky2;
`endif

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_mode = 1'b0;
    bit   forced_ready = 1'b1;

    add_seq_multiword #(.LEN(16), .NARG(4), .WORDS(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .A(a4), .IC(ic4), .out_valid(out_valid4), .out_ready(out_ready),
        .Y(y4), .out_last(out_last4), .OC(oc4), .OVF(ovf4)
`ifdef ADD_OVF_STICKY_EN
        , .ovf_clr(ovf_clr), .ovf_sticky(sticky4)
`endif
    );

    add_seq_multiword #(.LEN(16), .NARG(2), .WORDS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .A(a2), .IC(ic2), .out_valid(out_valid2), .out_ready(out_ready),
        .Y(y2), .out_last(out_last2), .OC(oc2), .OVF(ovf2)
`ifdef ADD_OVF_STICKY_EN
        , .ovf_clr(ovf_clr), .ovf_sticky(sticky2)
`endif
    );

    always #5 clk = ~clk;

    // Compare one value and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: whole 32-bit operands summed with plain integer
    // arithmetic, then beat w is sliced out of the result.
    function automatic exp_t modelBeat(input ops_t ops, input logic [1:0] ic, input int w);
        exp_t        e;
        logic [63:0] u4, u2;
        longint      s4, s2;
        longint      max_v = 64'sh0000_0000_7FFF_FFFF;
        longint      min_v = -64'sh0000_0000_8000_0000;
        u4 = 64'(ic);
        s4 = longint'(ic);
        for (int k = 0; k < 4; k++) begin
            u4 = u4 + 64'(ops[k]);
            s4 = s4 + longint'($signed(ops[k]));
        end
        u2 = 64'(ic[0]) + 64'(ops[0]) + 64'(ops[1]);
        s2 = longint'(ic[0]) + longint'($signed(ops[0])) + longint'($signed(ops[1]));
        e.last = (w == 1);
        e.y4   = u4[w*16 +: 16];
        e.y2   = u2[w*16 +: 16];
        e.oc4  = e.last ? u4[33:32] : 2'b00;
        e.oc2  = e.last ? u2[32] : 1'b0;
        e.ovf4 = e.last && ((s4 > max_v) || (s4 < min_v));
        e.ovf2 = e.last && ((s2 > max_v) || (s2 < min_v));
        return e;
    endfunction

    task automatic setInputs(input ops_t ops, input logic [1:0] ic, input int w);
        a4  = {ops[3][w*16 +: 16], ops[2][w*16 +: 16], ops[1][w*16 +: 16], ops[0][w*16 +: 16]};
        a2  = {ops[1][w*16 +: 16], ops[0][w*16 +: 16]};
        ic4 = ic;
        ic2 = ic[0];
    endtask

    // Present one beat from a negedge until accepted; queue its expectation.
    task automatic sendBeat(input ops_t ops, input logic [1:0] ic, input int w);
        bit done = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        setInputs(ops, ic, w);
        while (!done && n < 200) begin
            #4;
            if (in_ready4) begin
                sb.push_back(modelBeat(ops, ic, w));
                done = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    // Send a whole transaction, optionally with random idle gaps and junk data.
    task automatic applyStimulus(input ops_t ops, input logic [1:0] ic, input bit gaps);
        for (int w = 0; w < 2; w++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    a4  = {$urandom, $urandom};
                    a2  = $urandom;
                    ic4 = 2'($urandom);
                    ic2 = 1'($urandom);
                    @(negedge clk);
                end
            end
            sendBeat(ops, ic, w);
        end
    endtask

    task automatic drain();
        int n = 0;
        rand_mode    = 1'b0;
        forced_ready = 1'b1;
        while ((sb.size() != 0 || out_valid4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d queued expected 0", sb.size());
        end
    endtask

    function automatic logic [31:0] randWord();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Downstream ready, updated just after each negedge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Monitor: on every output handshake pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid4 && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL sb_underflow: got unexpected output beat Y=0x%0h expected none", y4);
                end else begin
                    e = sb.pop_front();
                    checkOutput("y_n4",      32'(y4),         32'(e.y4));
                    checkOutput("last_n4",   32'(out_last4),  32'(e.last));
                    checkOutput("oc_n4",     32'(oc4),        32'(e.oc4));
                    checkOutput("ovf_n4",    32'(ovf4),       32'(e.ovf4));
                    checkOutput("valid_n2",  32'(out_valid2), 32'(1));
                    checkOutput("y_n2",      32'(y2),         32'(e.y2));
                    checkOutput("last_n2",   32'(out_last2),  32'(e.last));
                    checkOutput("oc_n2",     32'(oc2),        32'(e.oc2));
                    checkOutput("ovf_n2",    32'(ovf2),       32'(e.ovf2));
                end
            end
        end
    end

    initial begin
        ops_t ops;
        exp_t e0;
        logic [1:0] ic;

        rst      = 1'b1;
        in_valid = 1'b0;
        a4       = '0;
        a2       = '0;
        ic4      = '0;
        ic2      = '0;
`ifdef ADD_OVF_STICKY_EN
        ovf_clr  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #4;
        checkOutput("rst_out_valid", 32'(out_valid4), 32'(0));
        checkOutput("rst_y",         32'(y4),         32'(0));
        checkOutput("rst_last",      32'(out_last4),  32'(0));
        checkOutput("rst_oc",        32'(oc4),        32'(0));
        checkOutput("rst_ovf",       32'(ovf4),       32'(0));
        checkOutput("rst_in_ready",  32'(in_ready4),  32'(1));
        @(negedge clk);
        rst = 1'b0;

        // Carry ripples into the upper word.
        ops = {32'h0, 32'h0, 32'h0000_0001, 32'h0000_FFFF};
        applyStimulus(ops, 2'd0, 1'b0);
        // Positive plus positive crosses into the sign bit.
        ops = {32'h0, 32'h0, 32'h0000_0001, 32'h7FFF_FFFF};
        applyStimulus(ops, 2'd0, 1'b0);
        // All ones with maximum carry-in.
        ops = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        applyStimulus(ops, 2'd3, 1'b0);
        drain();

        // Backpressure after the first beat: output held, input blocked.
        ops = {32'h1234_5678, 32'h0F0F_F0F0, 32'hDEAD_BEEF, 32'h8000_FFFF};
        ic  = 2'd2;
        e0  = modelBeat(ops, ic, 0);
        forced_ready = 1'b0;
        sendBeat(ops, ic, 0);
        in_valid = 1'b1;
        setInputs(ops, ic, 1);
        for (int i = 0; i < 3; i++) begin
            #4;
            checkOutput("stall_valid",    32'(out_valid4), 32'(1));
            checkOutput("stall_y",        32'(y4),         32'(e0.y4));
            checkOutput("stall_in_ready", 32'(in_ready4),  32'(0));
            @(negedge clk);
        end
        forced_ready = 1'b1;
        sendBeat(ops, ic, 1);
        drain();

        // Reset in the middle of a transaction discards the partial sum.
        ops = {32'hAAAA_0000, 32'h5555_0000, 32'h0000_FFFF, 32'h0000_FFFF};
        sendBeat(ops, 2'd1, 0);
        drain();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        ops = {32'h0, 32'h0, 32'h0000_0002, 32'h0000_0001};
        applyStimulus(ops, 2'd1, 1'b0);
        drain();

`ifdef ADD_OVF_STICKY_EN
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #4;
        checkOutput("sticky_cleared_n4", 32'(sticky4), 32'(0));
        @(negedge clk);
        ops = {32'h0, 32'h0, 32'h0000_0001, 32'h7FFF_FFFF};
        applyStimulus(ops, 2'd0, 1'b0);
        drain();
        checkOutput("sticky_set_n4", 32'(sticky4), 32'(1));
        checkOutput("sticky_set_n2", 32'(sticky2), 32'(1));
        ops = {32'h0, 32'h0, 32'h0000_0001, 32'h0000_FFFF};
        applyStimulus(ops, 2'd0, 1'b0);
        drain();
        checkOutput("sticky_hold_n4", 32'(sticky4), 32'(1));
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #4;
        checkOutput("sticky_clr_n4", 32'(sticky4), 32'(0));
        checkOutput("sticky_clr_n2", 32'(sticky2), 32'(0));
        @(negedge clk);
`endif

        // Randomized traffic with random gaps and random downstream stalls.
        rand_mode = 1'b1;
        for (int t = 0; t < 150; t++) begin
            ops = {randWord(), randWord(), randWord(), randWord()};
            ic  = 2'($urandom);
            applyStimulus(ops, ic, 1'b1);
        end
        drain();
        checkOutput("sb_empty", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
